// File: rtl/apb_gpio_deb_pkg.sv
// apb_gpio_deb_pkg
// Shared constants for the debounced APB GPIO block: register word indices
// (PADDR[7:2]), the highest mapped index and the interrupt mode encodings.
package apb_gpio_deb_pkg;

  localparam logic [5:0] IDX_INT_EN   = 6'd0;
  localparam logic [5:0] IDX_OUT      = 6'd1;
  localparam logic [5:0] IDX_OE       = 6'd2;
  localparam logic [5:0] IDX_IN       = 6'd3;
  localparam logic [5:0] IDX_INT_STAT = 6'd4;
  localparam logic [5:0] IDX_EDGE     = 6'd5;
  localparam logic [5:0] IDX_POL      = 6'd6;
  localparam logic [5:0] IDX_BOTH     = 6'd7;
  localparam logic [5:0] IDX_DEB_LEN  = 6'd8;
  localparam logic [5:0] IDX_RAW      = 6'd9;

  localparam logic [5:0] MAX_IDX      = 6'd9;

  // EDGE register bit values
  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;
  // POL register bit values
  localparam logic POL_HI     = 1'b1;
  localparam logic POL_LO     = 1'b0;

endpackage

// File: rtl/apb_gpio_deb_if.sv
// apb_gpio_deb_if
// APB3 slave-side bus bundle for apb_gpio_deb.
//   master : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives PRDATA/PREADY/PSLVERR
//   slave  : the opposite direction
interface apb_gpio_deb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_deb_ch.sv
// gpio_deb_ch
// One GPIO input channel: 2-flop synchroniser, programmable debouncer and
// interrupt event generation.
// Ports:
//   clk_i, rst_ni   clock / async active-low reset
//   gpio_i          asynchronous pad input
//   deb_len_i       debounce length (0 behaves as 1)
//   edge_i          1 = edge mode, 0 = level mode
//   pol_i           1 = rising/high, 0 = falling/low
//   both_i          edge mode only: event on both edges
//   ev_o            interrupt event (combinational, sampled by status reg)
//   stable_o        debounced value
//   raw_o           synchroniser output
module gpio_deb_ch
  import apb_gpio_deb_pkg::*;
#(
  parameter int unsigned DEB_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             gpio_i,
  input  logic [DEB_W-1:0] deb_len_i,
  input  logic             edge_i,
  input  logic             pol_i,
  input  logic             both_i,
  output logic             ev_o,
  output logic             stable_o,
  output logic             raw_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] last_cnt;
  logic             rise, fall;

  // Terminal count is D-1 with D = max(deb_len,1). Compare with >= so a
  // counter left above a freshly shortened length transfers on its next
  // mismatch instead of wrapping.
  assign last_cnt = (deb_len_i == '0) ? '0 : deb_len_i - 1'b1;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= last_cnt) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= gpio_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign rise = stable_q & ~stable_dly_q;
  assign fall = ~stable_q & stable_dly_q;

  always_comb begin
    if (edge_i == MODE_EDGE) begin
      if (both_i)               ev_o = rise | fall;
      else if (pol_i == POL_HI) ev_o = rise;
      else                      ev_o = fall;
    end else begin
      ev_o = (pol_i == POL_HI) ? stable_q : ~stable_q;
    end
  end

  assign stable_o = stable_q;
  assign raw_o    = sync2_q;

endmodule

// File: rtl/apb_gpio_deb.sv
// apb_gpio_deb
// APB GPIO slave with IO_NUM debounced inputs, pad OUT/OE registers and
// per-channel interrupts (level/edge, polarity, both-edge) with W1C status.
// Ports:
//   SYSCLK_apb, PRESETN   clock / async active-low reset
//   apb                   APB slave bus (no wait states)
//   GPIO_IN               asynchronous pad inputs
//   GPIO_OUT, GPIO_OE     OUT and OE registers
//   INT                   INT_STAT & INT_EN
//   INT_OR                OR of INT
module apb_gpio_deb
  import apb_gpio_deb_pkg::*;
#(
  parameter int unsigned        IO_NUM  = 8,
  parameter int unsigned        DEB_W   = 8,
  parameter logic [DEB_W-1:0]   DEB_RST = DEB_W'(4),
  parameter logic [IO_NUM-1:0]  OUT_RST = '0,
  parameter logic [IO_NUM-1:0]  OE_RST  = '0
) (
  input  logic              SYSCLK_apb,
  input  logic              PRESETN,
  apb_gpio_deb_if.slave     apb,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  logic [IO_NUM-1:0] int_en_q, int_en_d;
  logic [IO_NUM-1:0] out_q, out_d;
  logic [IO_NUM-1:0] oe_q, oe_d;
  logic [IO_NUM-1:0] stat_q, stat_d;
  logic [IO_NUM-1:0] edge_q, edge_d;
  logic [IO_NUM-1:0] pol_q, pol_d;
  logic [IO_NUM-1:0] both_q, both_d;
  logic [DEB_W-1:0]  deb_len_q, deb_len_d;

  logic [IO_NUM-1:0] ev, stable, raw;
  logic [IO_NUM-1:0] clr;
  logic [IO_NUM-1:0] wdata_io;
  logic [5:0]        word_idx;
  logic              wr_en;
  logic [31:0]       rdata;
  logic              unused_bus_bits;

  assign word_idx = apb.PADDR[7:2];
  assign wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wdata_io = apb.PWDATA[IO_NUM-1:0];
  assign unused_bus_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  for (genvar g = 0; g < IO_NUM; g++) begin : g_ch
    gpio_deb_ch #(.DEB_W(DEB_W)) u_ch (
      .clk_i     (SYSCLK_apb),
      .rst_ni    (PRESETN),
      .gpio_i    (GPIO_IN[g]),
      .deb_len_i (deb_len_q),
      .edge_i    (edge_q[g]),
      .pol_i     (pol_q[g]),
      .both_i    (both_q[g]),
      .ev_o      (ev[g]),
      .stable_o  (stable[g]),
      .raw_o     (raw[g])
    );
  end

  always_comb begin
    int_en_d  = int_en_q;
    out_d     = out_q;
    oe_d      = oe_q;
    edge_d    = edge_q;
    pol_d     = pol_q;
    both_d    = both_q;
    deb_len_d = deb_len_q;
    clr       = '0;
    if (wr_en) begin
      case (word_idx)
        IDX_INT_EN:   int_en_d  = wdata_io;
        IDX_OUT:      out_d     = wdata_io;
        IDX_OE:       oe_d      = wdata_io;
        IDX_INT_STAT: clr       = wdata_io;
        IDX_EDGE:     edge_d    = wdata_io;
        IDX_POL:      pol_d     = wdata_io;
        IDX_BOTH:     both_d    = wdata_io;
        IDX_DEB_LEN:  deb_len_d = apb.PWDATA[DEB_W-1:0];
        default:      ;
      endcase
    end
    // Set wins over a same-edge clear; events are captured even when masked.
    stat_d = (stat_q & ~clr) | ev;
  end

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      int_en_q  <= '0;
      out_q     <= OUT_RST;
      oe_q      <= OE_RST;
      stat_q    <= '0;
      edge_q    <= '0;
      pol_q     <= '0;
      both_q    <= '0;
      deb_len_q <= DEB_RST;
    end else begin
      int_en_q  <= int_en_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      stat_q    <= stat_d;
      edge_q    <= edge_d;
      pol_q     <= pol_d;
      both_q    <= both_d;
      deb_len_q <= deb_len_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (apb.PSEL) begin
      case (word_idx)
        IDX_INT_EN:   rdata[IO_NUM-1:0] = int_en_q;
        IDX_OUT:      rdata[IO_NUM-1:0] = out_q;
        IDX_OE:       rdata[IO_NUM-1:0] = oe_q;
        IDX_IN:       rdata[IO_NUM-1:0] = stable;
        IDX_INT_STAT: rdata[IO_NUM-1:0] = stat_q;
        IDX_EDGE:     rdata[IO_NUM-1:0] = edge_q;
        IDX_POL:      rdata[IO_NUM-1:0] = pol_q;
        IDX_BOTH:     rdata[IO_NUM-1:0] = both_q;
        IDX_DEB_LEN:  rdata[DEB_W-1:0]  = deb_len_q;
        IDX_RAW:      rdata[IO_NUM-1:0] = raw;
        default:      rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & (word_idx > MAX_IDX);

  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign INT      = stat_q & int_en_q;
  assign INT_OR   = |INT;

endmodule
